// File: rtl/goldsmith_div_ctrl_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer.
// Q1.23 constants, FSM encoding and the denormalisation shift helper.
package goldsmith_div_ctrl_pkg;

    localparam int          WIDTH    = 24;
    localparam logic [23:0] ONE_Q123 = 24'h800000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_NORM   = 3'd1,
        ST_RUN    = 3'd2,
        ST_DENORM = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    typedef struct packed {
        logic div0;
        logic ovf;
        logic tmo;
    } err_t;

    // Net binary-point move: lzB - lzA aligns the normalised operands, then Q1.23 -> OUT_FRAC.
    function automatic logic signed [6:0] denorm_shift(input logic [4:0] lza,
                                                       input logic [4:0] lzb,
                                                       input int unsigned frac);
        logic [6:0] s;
        s = 7'(lzb) - 7'(lza) + 7'(frac) - 7'd23;
        return $signed(s);
    endfunction

endpackage

// File: rtl/goldsmith_div_ctrl_if.sv
// Request/result handshake plus divider-side bus of the sequencer.
// slave = the sequencer, master = requester/consumer and divider side.
interface goldsmith_div_ctrl_if
    import goldsmith_div_ctrl_pkg::*;
#(
    parameter int OUT_W = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_quotient;
    logic             out_err_div0;
    logic             out_err_ovf;
    logic             out_err_tmo;
    logic             div_clk_en;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic [WIDTH-1:0] div_quotient;
    logic             div_res_ready;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready, div_quotient, div_res_ready,
        output in_ready, out_valid, out_quotient, out_err_div0, out_err_ovf, out_err_tmo,
               div_clk_en, div_dividend, div_divisor
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready, div_quotient, div_res_ready,
        input  in_ready, out_valid, out_quotient, out_err_div0, out_err_ovf, out_err_tmo,
               div_clk_en, div_dividend, div_divisor
    );
endinterface

// File: rtl/goldsmith_div_ctrl_lzc24.sv
// Combinational 24-bit leading-zero count; returns 24 for an all-zero input.
module goldsmith_div_ctrl_lzc24 (
    input  logic [23:0] val_i,
    output logic [4:0]  lz_o
);
    always_comb begin
        lz_o = 5'd24;
        // Ascending scan: the highest set bit is the last one to win.
        for (int i = 0; i < 24; i++) begin
            if (val_i[i]) lz_o = 5'(23 - i);
        end
    end
endmodule

// File: rtl/goldsmith_div_ctrl.sv
// Sequencer around the Goldschmidt divider: normalise, run via clock enable, rescale, saturate.
// One request in flight; in_ready low from accept until the result handshake completes.
module goldsmith_div_ctrl
    import goldsmith_div_ctrl_pkg::*;
#(
    parameter int OUT_W    = 24,
    parameter int OUT_FRAC = 12,
    parameter int SETTLE   = 2,
    parameter int MAX_WAIT = 32
) (
    input  logic                 g_clk,
    input  logic                 n_reset,
    goldsmith_div_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(SETTLE + MAX_WAIT + 1);
    localparam int EXT_W = WIDTH + 47;
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SETTLE + MAX_WAIT - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [4:0]         lza_q, lza_d, lzb_q, lzb_d;
    logic [4:0]         lz_a, lz_b;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   qraw_q, qraw_d;
    logic [OUT_W-1:0]   quo_q, quo_d;
    err_t               err_q, err_d;
    logic               en_q, en_d;
    logic [WIDTH-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;

    logic signed [6:0]  shift_s;
    logic [6:0]         shift_mag;
    logic [EXT_W-1:0]   ext;
    logic               ext_ovf;

    goldsmith_div_ctrl_lzc24 u_lzc_a (.val_i(a_q), .lz_o(lz_a));
    goldsmith_div_ctrl_lzc24 u_lzc_b (.val_i(b_q), .lz_o(lz_b));

    // Rescale the captured Q1.23 quotient; left shifts go through a wide intermediate for overflow.
    always_comb begin
        shift_s   = denorm_shift(lza_q, lzb_q, OUT_FRAC);
        shift_mag = 7'd0;
        ext       = EXT_W'(qraw_q);
        if (shift_s < 0) begin
            shift_mag = 7'(-shift_s);
            ext       = EXT_W'(qraw_q) >> shift_mag;
        end else begin
            shift_mag = $unsigned(shift_s);
            ext       = EXT_W'(qraw_q) << shift_mag;
        end
        ext_ovf = |ext[EXT_W-1:OUT_W];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        lza_d   = lza_q;
        lzb_d   = lzb_q;
        cnt_d   = cnt_q;
        qraw_d  = qraw_q;
        quo_d   = quo_q;
        err_d   = err_q;
        en_d    = en_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_dividend;
                    b_d     = bus.in_divisor;
                    err_d   = '0;
                    state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                lza_d = lz_a;
                lzb_d = lz_b;
                if (b_q == '0) begin
                    quo_d      = '1;
                    err_d.div0 = 1'b1;
                    state_d    = ST_DONE;
                end else if (a_q == '0) begin
                    quo_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    div_a_d = a_q << lz_a;
                    div_b_d = b_q << lz_b;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Ready is not trusted while the divider is still reloading.
                if (cnt_q >= CNT_SETTLE && bus.div_res_ready) begin
                    qraw_d  = bus.div_quotient;
                    en_d    = 1'b0;
                    state_d = ST_DENORM;
                end else if (cnt_q == CNT_LAST) begin
                    quo_d     = '1;
                    err_d.tmo = 1'b1;
                    en_d      = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DENORM: begin
                if (ext_ovf) begin
                    quo_d     = '1;
                    err_d.ovf = 1'b1;
                end else begin
                    quo_d = ext[OUT_W-1:0];
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            lza_q   <= '0;
            lzb_q   <= '0;
            cnt_q   <= '0;
            qraw_q  <= '0;
            quo_q   <= '0;
            err_q   <= '0;
            en_q    <= 1'b0;
            div_a_q <= '0;
            div_b_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lza_q   <= lza_d;
            lzb_q   <= lzb_d;
            cnt_q   <= cnt_d;
            qraw_q  <= qraw_d;
            quo_q   <= quo_d;
            err_q   <= err_d;
            en_q    <= en_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_IDLE);
    assign bus.out_valid    = (state_q == ST_DONE);
    assign bus.out_quotient = quo_q;
    assign bus.out_err_div0 = err_q.div0;
    assign bus.out_err_ovf  = err_q.ovf;
    assign bus.out_err_tmo  = err_q.tmo;
    assign bus.div_clk_en   = en_q;
    assign bus.div_dividend = div_a_q;
    assign bus.div_divisor  = div_b_q;

endmodule
